// File: rtl/izh_spike_decoder_if.sv
// Membrane-voltage input and spike-metric outputs of the spike decoder.
//   ena        : tile enable (master -> slave)
//   v_int      : signed membrane-voltage integer part (master -> slave)
//   spike_out  : one-cycle spike pulse
//   isi        : last inter-spike interval, isi_valid pulses on update
//   rate       : spikes in last completed window, rate_valid pulses on update
//   burst      : high while inside a burst
//   burst_len  : spike count of last completed burst, burst_done pulses on update
interface izh_spike_decoder_if;
    logic               ena;
    logic signed [7:0]  v_int;
    logic               spike_out;
    logic [15:0]        isi;
    logic               isi_valid;
    logic [7:0]         rate;
    logic               rate_valid;
    logic               burst;
    logic [7:0]         burst_len;
    logic               burst_done;

    modport master (
        output ena, v_int,
        input  spike_out, isi, isi_valid, rate, rate_valid, burst, burst_len, burst_done
    );

    modport slave (
        input  ena, v_int,
        output spike_out, isi, isi_valid, rate, rate_valid, burst, burst_len, burst_done
    );
endinterface

// File: rtl/izh_spike_decoder.sv
// Decodes an Izhikevich membrane-voltage stream into spike pulses, inter-spike
// interval, windowed firing rate and burst length.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : izh_spike_decoder_if slave (ena/v_int in, spike metrics out)
module izh_spike_decoder #(
    parameter logic signed [7:0] THRESH    = 8'sd30,
    parameter logic signed [7:0] REARM     = 8'sd0,
    parameter int unsigned       WINDOW    = 1000,
    parameter int unsigned       BURST_ISI = 64
) (
    input  logic                clk,
    input  logic                rst,
    izh_spike_decoder_if.slave  bus
);
    localparam int unsigned CW = 16;
    localparam int unsigned RW = 8;
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [RW-1:0] SAT8_MAX  = '1;
    localparam logic [CW-1:0] WIN_LAST  = CW'(WINDOW - 1);
    localparam logic [CW-1:0] BURST_LIM = CW'(BURST_ISI);

    typedef enum logic {ARMED, REFRACT} state_t;

    state_t         state;
    state_t         state_nx;
    logic           det;

    logic [CW-1:0]  isi_cnt;
    logic           seen_first;
    logic [RW-1:0]  burst_cnt;
    logic [CW-1:0]  win_cnt;
    logic [RW-1:0]  spk_cnt;

    logic           spike_q;
    logic [CW-1:0]  isi_q;
    logic           isi_valid_q;
    logic [RW-1:0]  rate_q;
    logic           rate_valid_q;
    logic           burst_q;
    logic [RW-1:0]  burst_len_q;
    logic           burst_done_q;

    logic [CW-1:0]  isi_meas;
    logic           short_isi;
    logic           burst_timeout;
    logic           win_wrap;
    logic [RW-1:0]  spk_sum;

    // Detector state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARMED;
        end else begin
            state <= state_nx;
        end
    end

    // Threshold/re-arm hysteresis; a re-arming sample can never also detect
    always_comb begin
        state_nx = state;
        det      = 1'b0;
        if (bus.ena) begin
            case (state)
                ARMED: begin
                    if ($signed(bus.v_int) >= THRESH) begin
                        det      = 1'b1;
                        state_nx = REFRACT;
                    end
                end
                REFRACT: begin
                    if ($signed(bus.v_int) <= REARM) begin
                        state_nx = ARMED;
                    end
                end
                default: state_nx = ARMED;
            endcase
        end
    end

    // Interval ending at this sample, saturating
    assign isi_meas      = (isi_cnt == CNT_MAX) ? CNT_MAX : isi_cnt + CW'(1);
    assign short_isi     = isi_meas < BURST_LIM;
    // Quiet for BURST_ISI cycles closes an open burst
    assign burst_timeout = burst_q && !det && (isi_meas == BURST_LIM);
    assign win_wrap      = (win_cnt == WIN_LAST);
    // Window spike count including a spike on this very sample
    assign spk_sum       = (det && spk_cnt != SAT8_MAX) ? spk_cnt + RW'(1) : spk_cnt;

    // Interval, burst and rate bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            isi_cnt      <= '0;
            seen_first   <= 1'b0;
            burst_cnt    <= '0;
            win_cnt      <= '0;
            spk_cnt      <= '0;
            spike_q      <= 1'b0;
            isi_q        <= '0;
            isi_valid_q  <= 1'b0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
            burst_q      <= 1'b0;
            burst_len_q  <= '0;
            burst_done_q <= 1'b0;
        end else begin
            spike_q      <= 1'b0;
            isi_valid_q  <= 1'b0;
            rate_valid_q <= 1'b0;
            burst_done_q <= 1'b0;
            if (bus.ena) begin
                spike_q <= det;
                isi_cnt <= det ? '0 : isi_meas;

                if (det) begin
                    seen_first <= 1'b1;
                    if (seen_first) begin
                        isi_q       <= isi_meas;
                        isi_valid_q <= 1'b1;
                        if (short_isi) begin
                            if (!burst_q) begin
                                burst_q   <= 1'b1;
                                burst_cnt <= RW'(2);
                            end else if (burst_cnt != SAT8_MAX) begin
                                burst_cnt <= burst_cnt + RW'(1);
                            end
                        end else if (burst_q) begin
                            // Closing spike is not part of the burst
                            burst_q      <= 1'b0;
                            burst_len_q  <= burst_cnt;
                            burst_done_q <= 1'b1;
                        end
                    end
                end else if (burst_timeout) begin
                    burst_q      <= 1'b0;
                    burst_len_q  <= burst_cnt;
                    burst_done_q <= 1'b1;
                end

                if (win_wrap) begin
                    win_cnt      <= '0;
                    rate_q       <= spk_sum;
                    rate_valid_q <= 1'b1;
                    spk_cnt      <= '0;
                end else begin
                    win_cnt <= win_cnt + CW'(1);
                    spk_cnt <= spk_sum;
                end
            end
        end
    end

    assign bus.spike_out  = spike_q;
    assign bus.isi        = isi_q;
    assign bus.isi_valid  = isi_valid_q;
    assign bus.rate       = rate_q;
    assign bus.rate_valid = rate_valid_q;
    assign bus.burst      = burst_q;
    assign bus.burst_len  = burst_len_q;
    assign bus.burst_done = burst_done_q;
endmodule

// File: tb/tb_izh_spike_decoder.sv
// Directed bench for izh_spike_decoder with a per-cycle expected-output queue.
module tb_izh_spike_decoder;
    localparam int WIN = 100;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    izh_spike_decoder_if bus();

    izh_spike_decoder #(
        .THRESH(8'sd30), .REARM(8'sd0), .WINDOW(WIN), .BURST_ISI(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        spike;
        logic [15:0] isi;
        logic        iv;
        logic [7:0]  rate;
        logic        rv;
        logic        burst;
        logic [7:0]  blen;
        logic        bd;
    } exp_t;

    exp_t sb[$];

    // Reference model state
    bit   m_arm = 1'b1;
    int   m_cnt = 0, m_seen = 0, m_burst = 0, m_bcnt = 0, m_win = 0, m_spk = 0;
    exp_t m_out = '0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic void model(input logic r, input logic e, input logic signed [7:0] v);
        exp_t n;
        bit   det;
        int   meas;
        int   spk;
        n = m_out;
        n.spike = 1'b0; n.iv = 1'b0; n.rv = 1'b0; n.bd = 1'b0;
        if (r) begin
            m_arm = 1'b1; m_cnt = 0; m_seen = 0; m_burst = 0; m_bcnt = 0;
            m_win = 0; m_spk = 0;
            n = '0;
        end else if (e) begin
            det  = m_arm && (int'(v) >= 30);
            if (m_arm) begin
                if (det) m_arm = 1'b0;
            end else if (int'(v) <= 0) begin
                m_arm = 1'b1;
            end
            meas = (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
            n.spike = det;
            if (det) begin
                if (m_seen != 0) begin
                    n.isi = 16'(meas);
                    n.iv  = 1'b1;
                    if (meas < 64) begin
                        if (m_burst == 0) begin
                            m_burst = 1; m_bcnt = 2;
                        end else begin
                            m_bcnt = (m_bcnt >= 255) ? 255 : m_bcnt + 1;
                        end
                    end else if (m_burst != 0) begin
                        m_burst = 0; n.blen = 8'(m_bcnt); n.bd = 1'b1;
                    end
                end
                m_seen = 1;
                m_cnt  = 0;
            end else begin
                if (m_burst != 0 && meas == 64) begin
                    m_burst = 0; n.blen = 8'(m_bcnt); n.bd = 1'b1;
                end
                m_cnt = meas;
            end
            spk = m_spk + (det ? 1 : 0);
            if (spk > 255) spk = 255;
            if (m_win == WIN - 1) begin
                n.rate = 8'(spk); n.rv = 1'b1; m_spk = 0; m_win = 0;
            end else begin
                m_spk = spk; m_win++;
            end
        end
        n.burst = (m_burst != 0);
        m_out = n;
        sb.push_back(n);
    endfunction

    task automatic check_cycle();
        exp_t x;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        x = sb.pop_front();
        chk("spike_out",  16'(bus.spike_out),  16'(x.spike));
        chk("isi",        bus.isi,             x.isi);
        chk("isi_valid",  16'(bus.isi_valid),  16'(x.iv));
        chk("rate",       16'(bus.rate),       16'(x.rate));
        chk("rate_valid", 16'(bus.rate_valid), 16'(x.rv));
        chk("burst",      16'(bus.burst),      16'(x.burst));
        chk("burst_len",  16'(bus.burst_len),  16'(x.blen));
        chk("burst_done", 16'(bus.burst_done), 16'(x.bd));
    endtask

    // One clock: drive, predict, then sample 1 ns after the edge
    task automatic step(input logic r, input logic e, input logic signed [7:0] v);
        rst       = r;
        bus.ena   = e;
        bus.v_int = v;
        model(r, e, v);
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, -8'sd65);
    endtask

    int spikes;
    int done_at;
    int done_len;
    int rv_at;
    int bd_cnt;

    initial begin
        rst = 1'b1; bus.ena = 1'b1; bus.v_int = 8'sd50;
        @(posedge clk); #1;

        // 1: reset holds everything at zero, first sample after release spikes
        step(1'b1, 1'b1, 8'sd50);
        step(1'b1, 1'b1, 8'sd50);
        chk("t1_rst_spike", 16'(bus.spike_out), 16'd0);
        step(1'b0, 1'b1, 8'sd50);
        chk("t1_first_spike", 16'(bus.spike_out), 16'd1);
        chk("t1_first_no_isi", 16'(bus.isi_valid), 16'd0);
        quiet(3);

        // 2: periodic spikes, ISI 20
        step(1'b1, 1'b1, -8'sd65);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 8'sd31);
            chk("t2_spike", 16'(bus.spike_out), 16'd1);
            chk("t2_isi_valid", 16'(bus.isi_valid), (k > 0) ? 16'd1 : 16'd0);
            if (k > 0) chk("t2_isi", bus.isi, 16'd20);
            quiet(19);
        end

        // 3: hysteresis
        step(1'b1, 1'b1, -8'sd65);
        spikes = 0;
        step(1'b0, 1'b1, 8'sd35);  spikes += int'(bus.spike_out);
        chk("t3_first35", 16'(bus.spike_out), 16'd1);
        step(1'b0, 1'b1, 8'sd35);  spikes += int'(bus.spike_out);
        step(1'b0, 1'b1, 8'sd10);  spikes += int'(bus.spike_out);
        step(1'b0, 1'b1, 8'sd40);  spikes += int'(bus.spike_out);
        step(1'b0, 1'b1, -8'sd5);  spikes += int'(bus.spike_out);
        step(1'b0, 1'b1, 8'sd40);  spikes += int'(bus.spike_out);
        chk("t3_last40", 16'(bus.spike_out), 16'd1);
        chk("t3_spike_count", 16'(spikes), 16'd2);
        quiet(2);

        // 4: four-spike burst at ISI 10 then quiet
        step(1'b1, 1'b1, -8'sd65);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 8'sd31);
            if (k == 0) chk("t4_no_burst_first", 16'(bus.burst), 16'd0);
            if (k == 1) chk("t4_burst_rise", 16'(bus.burst), 16'd1);
            if (k < 3) quiet(9);
        end
        done_at = 0; done_len = 0;
        for (int j = 1; j <= 90; j++) begin
            step(1'b0, 1'b1, -8'sd65);
            if (bus.burst_done && done_at == 0) begin
                done_at  = j;
                done_len = int'(bus.burst_len);
                chk("t4_burst_fall", 16'(bus.burst), 16'd0);
            end
        end
        chk("t4_done_at", 16'(done_at), 16'd64);
        chk("t4_burst_len", 16'(done_len), 16'd4);

        // 5: rate window, spike on the wrap cycle belongs to the closing window
        step(1'b1, 1'b1, -8'sd65);
        for (int i = 0; i < 2 * WIN; i++) begin
            step(1'b0, 1'b1, (i % 20 == 19) ? 8'sd31 : -8'sd65);
            if (i % WIN == WIN - 1) begin
                chk("t5_rate_valid", 16'(bus.rate_valid), 16'd1);
                chk("t5_rate", 16'(bus.rate), 16'd5);
                chk("t5_wrap_spike", 16'(bus.spike_out), 16'd1);
            end
        end

        // 6: enable gaps do not count toward ISI; reset drops partial state
        step(1'b1, 1'b1, -8'sd65);
        step(1'b0, 1'b1, 8'sd31);
        quiet(10);
        for (int i = 0; i < 50; i++) step(1'b0, 1'b0, 8'sd50);
        quiet(19);
        step(1'b0, 1'b1, 8'sd31);
        chk("t6_isi_valid", 16'(bus.isi_valid), 16'd1);
        chk("t6_isi", bus.isi, 16'd30);
        step(1'b0, 1'b0, -8'sd65);
        chk("t6_no_stretch", 16'(bus.spike_out), 16'd0);
        quiet(5);
        step(1'b1, 1'b1, -8'sd65);
        rv_at = -1; bd_cnt = 0;
        for (int i = 0; i < WIN + 20; i++) begin
            step(1'b0, 1'b1, -8'sd65);
            if (bus.rate_valid && rv_at < 0) rv_at = i;
            bd_cnt += int'(bus.burst_done);
        end
        chk("t6_rate_valid_at", 16'(rv_at), 16'(WIN - 1));
        chk("t6_no_burst_done", 16'(bd_cnt), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/izh_spike_decoder.md
Name: izh_spike_decoder

Overview:
- Sits on the output side of the Izhikevich neuron tile and decodes its membrane-voltage stream back into spike-train metrics.
- Samples the signed 8-bit integer part of v each enabled cycle and detects spikes with threshold/re-arm hysteresis.
- Measures inter-spike interval (ISI), windowed firing rate and burst length, so the host can classify firing behaviour (RS/IB/CH/FS…) from pins.

Parameters:
THRESH, 30, signed 8-bit spike-detect level; spike when v_int >= THRESH while armed
REARM, 0, signed 8-bit re-arm level; detector re-arms when v_int <= REARM
WINDOW, 1000, rate window length in enabled cycles (1..65535)
BURST_ISI, 64, ISI strictly below this value marks a burst spike (1..65535)

Ports:
clk  in  1  clock; single clock domain
rst  in  1  synchronous, active-high reset
ena  in  1  tile enable; when low, all state holds
v_int  in  8  signed membrane-voltage integer part from the neuron
spike_out  out  1  one-cycle pulse per detected spike
isi  out  16  last measured ISI in enabled cycles, saturating at 16'hFFFF
isi_valid  out  1  one-cycle pulse when isi updates
rate  out  8  spikes counted in last completed window, saturating at 255
rate_valid  out  1  one-cycle pulse when rate updates
burst  out  1  high while inside a burst
burst_len  out  8  spike count of the last completed burst, saturating at 255
burst_done  out  1  one-cycle pulse when burst_len updates

Behaviour:
- Reset (rst=1 at clk edge):
  - FSM enters ARMED.
  - All counters are cleared, seen_first is cleared, and every output becomes 0.
- Reset mid-operation discards partial window, partial ISI and partial burst with no pulses.
- ena=0:
  - No detection, no counter advance, registers hold.
  - All *_valid, spike_out and burst_done pulses are 0.
  - ena low does not stretch a pulse: pulses last exactly one clk cycle.
- Detection FSM, with v_int compared as signed:
  - ARMED: if v_int >= THRESH, then spike_out=1 on the next cycle (1-cycle latency from sample) and go to REFRACT.
  - REFRACT: if v_int <= REARM, go to ARMED. No detection while in REFRACT.
  - A sample >= THRESH in the same cycle the FSM re-arms is not a spike; re-arm takes effect on the next sample.
- ISI counter:
  - Cleared to 0 on the spike-detect cycle; increments by 1 each enabled cycle after; saturates at 16'hFFFF.
  - On a spike with seen_first=1: isi <= counter+1 (saturating) and isi_valid pulses together with spike_out. Example: detects at enabled cycles 10 and 25 give isi=15.
  - The first spike after reset sets seen_first and produces no isi_valid.
- Burst tracking:
  - On a spike with a valid ISI < BURST_ISI:
    - If burst=0: burst <= 1 and burst counter <= 2.
    - Otherwise: burst counter increments, saturating at 255.
  - When burst=1 and the ISI counter reaches BURST_ISI with no spike, or when a spike arrives with ISI >= BURST_ISI:
    - burst <= 0, burst_len <= burst counter, burst_done pulses.
    - A spike that ends a burst is not counted in it.
- Rate window:
  - Window counter runs 0..WINDOW-1 on enabled cycles and wraps.
  - On the wrap cycle: rate <= spike count including any spike detected on that same cycle, rate_valid pulses, and the spike count restarts at 0.
  - Spike count saturates at 255.
- All outputs are registered; there are no combinational paths from v_int to outputs.

Test Plan:
1. rst=1 for 2 cycles with v_int=50 -> all outputs 0 and no spike_out; after release, spike_out pulses 1 cycle after the first v_int=50 sample.
2. Periodic spikes: v_int=31 for 1 cycle then -65 for 19 cycles, repeated -> first spike has no isi_valid; each later spike gives isi=20 with isi_valid coincident with spike_out.
3. Hysteresis: v_int sequence 35,35,10,40,-5,40 -> exactly 2 spikes, at the first 35 and at the final 40.
4. Burst: 4 spikes at ISI=10, then quiet -> burst rises at spike 2; burst_done with burst_len=4 fires 64 cycles after spike 4, and burst falls at the same time.
5. Rate with WINDOW=100, spikes every 20 cycles starting at cycle 19 -> rate=5 and rate_valid at each wrap; a spike on the wrap cycle is counted in the closing window.
6. ena=0 for 50 cycles between two spikes 30 enabled cycles apart, and rst asserted mid-window -> isi=30; after reset, rate_valid next occurs WINDOW cycles later with no burst_done.
